// File: rtl/dmem_axil_bridge_pkg.sv
// Shared definitions for the MEM-stage to AXI4-Lite data bridge:
// response codes, FSM state encodings and a response classification helper.
package dmem_axil_bridge_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_WR_B = 3'd2;
  localparam logic [2:0] ST_RD_A = 3'd3;
  localparam logic [2:0] ST_RD_D = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Anything other than OKAY is reported to the pipeline as a bus error.
  function automatic logic resp_is_err(input axi_resp_t resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/dmem_axil_bridge.sv
// Turns one MEM-stage load/store into a single AXI4-Lite transaction and
// stalls the pipeline until the response has come back.
module dmem_axil_bridge
  import dmem_axil_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  mem_r,
  input  logic                  mem_w,
  input  logic [DATA_W/8-1:0]   mem_w_strb,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_w_data,
  output logic [DATA_W-1:0]     mem_r_data,
  output logic                  mem_stall,
  output logic                  mem_err,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic                awvalid_r;
  logic                wvalid_r;
  logic                arvalid_r;
  logic                bready_r;
  logic                rready_r;
  logic [ADDR_W-1:0]   awaddr_r;
  logic [ADDR_W-1:0]   araddr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic [DATA_W-1:0]   r_data_r;
  logic                err_r;
  logic                start_wr_s;
  logic                start_rd_s;
  logic                aw_left_s;
  logic                w_left_s;
  logic                busy_s;

  // A simultaneous load and store request is issued as a store.
  assign start_wr_s = (state_r == ST_IDLE) && mem_w;
  assign start_rd_s = (state_r == ST_IDLE) && mem_r && !mem_w;
  assign aw_left_s  = awvalid_r && !m_awready;
  assign w_left_s   = wvalid_r && !m_wready;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_w) begin
          state_nxt_s = ST_WR;
        end else if (mem_r) begin
          state_nxt_s = ST_RD_A;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if (!aw_left_s && !w_left_s) begin
          state_nxt_s = ST_WR_B;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_WR_B: begin
        if (m_bvalid) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WR_B;
        end
      end
      ST_RD_A: begin
        if (arvalid_r && m_arready) begin
          state_nxt_s = ST_RD_D;
        end else begin
          state_nxt_s = ST_RD_A;
        end
      end
      ST_RD_D: begin
        if (m_rvalid) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RD_D;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and channel valid/ready flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      arvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      rready_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      awvalid_r <= start_wr_s | aw_left_s;
      wvalid_r  <= start_wr_s | w_left_s;
      arvalid_r <= start_rd_s | (arvalid_r & ~m_arready);
      bready_r  <= (state_nxt_s == ST_WR_B);
      rready_r  <= (state_nxt_s == ST_RD_D);
    end
  end

  // Request payload is captured once, as the FSM leaves IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr_r <= {ADDR_W{1'b0}};
      araddr_r <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      wstrb_r  <= {(DATA_W/8){1'b0}};
    end else begin
      if (start_wr_s) begin
        awaddr_r <= mem_addr & ALIGN_MASK;
        wdata_r  <= mem_w_data;
        wstrb_r  <= mem_w_strb;
      end
      if (start_rd_s) begin
        araddr_r <= mem_addr & ALIGN_MASK;
      end
    end
  end

  // Response capture; err_r is only ever high in the DONE cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data_r <= {DATA_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if ((state_r == ST_RD_D) && m_rvalid) begin
        r_data_r <= m_rdata;
        err_r    <= resp_is_err(m_rresp);
      end else if ((state_r == ST_WR_B) && m_bvalid) begin
        err_r    <= resp_is_err(m_bresp);
      end else begin
        err_r    <= 1'b0;
      end
    end
  end

  // Stall covers the request cycle in IDLE and every wait state, never DONE.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ST_IDLE: busy_s = mem_r | mem_w;
      ST_WR:   busy_s = 1'b1;
      ST_WR_B: busy_s = 1'b1;
      ST_RD_A: busy_s = 1'b1;
      ST_RD_D: busy_s = 1'b1;
      ST_DONE: busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  assign mem_stall  = aresetn & busy_s;
  assign mem_err    = err_r;
  assign mem_r_data = r_data_r;
  assign m_awaddr   = awaddr_r;
  assign m_awvalid  = awvalid_r;
  assign m_wdata    = wdata_r;
  assign m_wstrb    = wstrb_r;
  assign m_wvalid   = wvalid_r;
  assign m_bready   = bready_r;
  assign m_araddr   = araddr_r;
  assign m_arvalid  = arvalid_r;
  assign m_rready   = rready_r;

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Bench for dmem_axil_bridge: random AXI4-Lite slave timing, a transaction-level
// model of stall/valid/response behaviour checked every cycle, plus directed cases.
module tb_dmem_axil_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        mem_r, mem_w;
  logic [3:0]  mem_w_strb;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        mem_stall, mem_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  dmem_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .mem_r(mem_r), .mem_w(mem_w), .mem_w_strb(mem_w_strb), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .mem_stall(mem_stall), .mem_err(mem_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial forever #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-instruction parameters chosen by the driver, read by slave and model.
  logic [1:0]  tx_resp = 2'b00;
  logic [31:0] tx_rdata = 32'h0;
  int d_aw = 0, d_w = 0, d_ar = 0, d_rsp = 0;
  int instr_id = 0;
  int rst_epoch = 0;
  bit chk_en = 1'b0;

  // Observations gathered by the model process.
  int n_aw = 0, n_w = 0, n_ar = 0, n_resp = 0;
  logic [31:0] last_awaddr = 32'h0, last_wdata = 32'h0, last_araddr = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AXI4-Lite slave ----------------
  int s_aw_c = 0, s_w_c = 0, s_ar_c = 0, s_b_wait = 0, s_r_wait = 0;
  bit s_aw_got = 0, s_w_got = 0, s_b_pend = 0, s_r_pend = 0;
  bit hs_aw = 0, hs_w = 0, hs_ar = 0, hs_b = 0, hs_r = 0;

  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        s_aw_c = 0; s_w_c = 0; s_ar_c = 0; s_aw_got = 0; s_w_got = 0; s_b_pend = 0; s_r_pend = 0;
        hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
      end else begin
        if (hs_aw) s_aw_got = 1;
        if (hs_w) s_w_got = 1;
        if (s_aw_got && s_w_got) begin
          s_aw_got = 0; s_w_got = 0; s_b_pend = 1; s_b_wait = d_rsp;
        end
        if (hs_ar) begin s_r_pend = 1; s_r_wait = d_rsp; end
        if (hs_b) m_bvalid = 1'b0;
        if (hs_r) m_rvalid = 1'b0;
        if (s_b_pend) begin
          if (s_b_wait == 0) begin m_bvalid = 1'b1; m_bresp = tx_resp; s_b_pend = 0; end
          else s_b_wait--;
        end
        if (s_r_pend) begin
          if (s_r_wait == 0) begin
            m_rvalid = 1'b1; m_rresp = tx_resp; m_rdata = tx_rdata; s_r_pend = 0;
          end else s_r_wait--;
        end
        if (m_awvalid) begin m_awready = (s_aw_c >= d_aw); s_aw_c++; end
        else begin m_awready = 1'b0; s_aw_c = 0; end
        if (m_wvalid) begin m_wready = (s_w_c >= d_w); s_w_c++; end
        else begin m_wready = 1'b0; s_w_c = 0; end
        if (m_arvalid) begin m_arready = (s_ar_c >= d_ar); s_ar_c++; end
        else begin m_arready = 1'b0; s_ar_c = 0; end
        hs_aw = m_awvalid && m_awready;
        hs_w  = m_wvalid && m_wready;
        hs_ar = m_arvalid && m_arready;
        hs_b  = m_bvalid && m_bready;
        hs_r  = m_rvalid && m_rready;
      end
    end
  end

  // ---------------- transaction-level model and per-cycle compare ----------------
  int  c_seen_id = -1, c_seen_ep = 0;
  bit  c_started = 0, c_aw_d = 0, c_w_d = 0, c_ar_d = 0, c_rsp_d = 0;
  bit  c_is_wr = 0, c_is_rd = 0, c_done = 0;
  logic [31:0] c_hold = 32'h0;

  initial begin
    forever begin
      @(negedge aclk);
      #2;
      if (chk_en) begin
        if (rst_epoch != c_seen_ep) begin c_seen_ep = rst_epoch; c_hold = 32'h0; end
        if (instr_id != c_seen_id) begin
          c_seen_id = instr_id; c_started = 0; c_aw_d = 0; c_w_d = 0; c_ar_d = 0; c_rsp_d = 0;
          n_aw = 0; n_w = 0; n_ar = 0; n_resp = 0;
        end
        c_is_wr = mem_w;
        c_is_rd = mem_r && !mem_w;
        c_done  = c_rsp_d;
        if (c_done && c_is_rd) c_hold = tx_rdata;
        chk("mem_stall", {31'd0, mem_stall}, {31'd0, (c_is_wr || c_is_rd) && !c_done});
        chk("mem_err", {31'd0, mem_err}, {31'd0, c_done && (tx_resp != 2'b00)});
        chk("mem_r_data", mem_r_data, c_hold);
        chk("m_awvalid", {31'd0, m_awvalid}, {31'd0, c_is_wr && c_started && !c_aw_d});
        chk("m_wvalid", {31'd0, m_wvalid}, {31'd0, c_is_wr && c_started && !c_w_d});
        chk("m_bready", {31'd0, m_bready}, {31'd0, c_is_wr && c_aw_d && c_w_d && !c_rsp_d});
        chk("m_arvalid", {31'd0, m_arvalid}, {31'd0, c_is_rd && c_started && !c_ar_d});
        chk("m_rready", {31'd0, m_rready}, {31'd0, c_is_rd && c_ar_d && !c_rsp_d});
        if (m_awvalid) chk("m_awaddr", m_awaddr, mem_addr & 32'hFFFF_FFFC);
        if (m_wvalid) begin
          chk("m_wdata", m_wdata, mem_w_data);
          chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, mem_w_strb});
        end
        if (m_arvalid) chk("m_araddr", m_araddr, mem_addr & 32'hFFFF_FFFC);
        if (m_awvalid && m_awready) begin c_aw_d = 1; n_aw++; last_awaddr = m_awaddr; end
        if (m_wvalid && m_wready) begin
          c_w_d = 1; n_w++; last_wdata = m_wdata; last_wstrb = m_wstrb;
        end
        if (m_arvalid && m_arready) begin c_ar_d = 1; n_ar++; last_araddr = m_araddr; end
        if ((m_bvalid && m_bready) || (m_rvalid && m_rready)) begin c_rsp_d = 1; n_resp++; end
        if (c_is_wr || c_is_rd) c_started = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_instr(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [1:0] rsp, input logic [31:0] rd,
                          input int daw, input int dw, input int dar, input int drsp,
                          output int stalls);
    @(negedge aclk);
    mem_r = r; mem_w = w; mem_addr = a; mem_w_data = wd; mem_w_strb = st;
    tx_resp = rsp; tx_rdata = rd; d_aw = daw; d_w = dw; d_ar = dar; d_rsp = drsp;
    instr_id++;
    stalls = 0;
    #1;
    while (mem_stall && stalls < 300) begin
      stalls++;
      @(negedge aclk);
      #1;
    end
    if (mem_stall) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: stall still 1 after %0d cycles, expected release", stalls);
    end
  endtask

  int st_cnt;
  int guard;

  initial begin
    aresetn = 1'b0;
    mem_r = 1'b1; mem_w = 1'b0; mem_w_strb = 4'h0; mem_addr = 32'h0; mem_w_data = 32'h0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst mem_r_data", mem_r_data, 32'd0);
    chk("rst valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, 1'b0}, 32'd0);
    chk("rst readies", {30'd0, m_bready, m_rready}, 32'd0);
    chk("rst awaddr", m_awaddr, 32'd0);
    chk("rst araddr", m_araddr, 32'd0);
    chk("rst wdata", m_wdata, 32'd0);
    chk("rst wstrb", {28'd0, m_wstrb}, 32'd0);
    @(negedge aclk);
    mem_r = 1'b0; aresetn = 1'b1; chk_en = 1'b1;

    // zero-wait load from an unaligned address
    do_instr(1, 0, 32'h0000_1006, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF, 0, 0, 0, 0, st_cnt);
    chk("load stall cycles", st_cnt, 32'd3);
    chk("load araddr", last_araddr, 32'h0000_1004);
    chk("load data", mem_r_data, 32'hDEAD_BEEF);
    chk("load AR count", n_ar, 32'd1);
    chk("load AW count", n_aw, 32'd0);
    chk("load err", {31'd0, mem_err}, 32'd0);

    // store with awready two cycles after wready
    do_instr(0, 1, 32'h0000_2002, 32'h1234_0000, 4'b1100, 2'b00, 32'h0, 2, 0, 0, 0, st_cnt);
    chk("store stall cycles", st_cnt, 32'd5);
    chk("store awaddr", last_awaddr, 32'h0000_2000);
    chk("store wdata", last_wdata, 32'h1234_0000);
    chk("store wstrb", {28'd0, last_wstrb}, 32'h0000_000C);
    chk("store B count", n_resp, 32'd1);
    chk("store err", {31'd0, mem_err}, 32'd0);

    // back-to-back load then store
    do_instr(1, 0, 32'h0000_3000, 32'h0, 4'h0, 2'b00, 32'hCAFE_0001, 0, 0, 0, 0, st_cnt);
    chk("b2b load stalls", st_cnt, 32'd3);
    chk("b2b AR count", n_ar, 32'd1);
    do_instr(0, 1, 32'h0000_3008, 32'hA5A5_0F0F, 4'b1111, 2'b00, 32'h0, 0, 0, 0, 0, st_cnt);
    chk("b2b store stalls", st_cnt, 32'd3);
    chk("b2b AW count", n_aw, 32'd1);
    chk("b2b W count", n_w, 32'd1);
    chk("b2b held rdata", mem_r_data, 32'hCAFE_0001);

    // error response on a load, then a clean store
    do_instr(1, 0, 32'h0000_4000, 32'h0, 4'h0, 2'b10, 32'h5A5A_A5A5, 0, 0, 1, 1, st_cnt);
    chk("slverr pulse", {31'd0, mem_err}, 32'd1);
    chk("slverr data", mem_r_data, 32'h5A5A_A5A5);
    do_instr(0, 1, 32'h0000_4004, 32'h1, 4'b0001, 2'b00, 32'h0, 0, 1, 0, 0, st_cnt);
    chk("okay after err", {31'd0, mem_err}, 32'd0);

    // load and store together behave as a store
    do_instr(1, 1, 32'h0000_5003, 32'h7777_8888, 4'b0011, 2'b11, 32'h0, 1, 1, 0, 2, st_cnt);
    chk("both: AR count", n_ar, 32'd0);
    chk("both: AW count", n_aw, 32'd1);
    chk("both: decerr", {31'd0, mem_err}, 32'd1);

    // asynchronous reset while waiting for read data
    @(negedge aclk);
    mem_r = 1'b1; mem_w = 1'b0; mem_addr = 32'h0000_6000; tx_resp = 2'b00; tx_rdata = 32'h1111_2222;
    d_ar = 0; d_rsp = 6; instr_id++;
    guard = 0;
    #1;
    while (!m_rready && guard < 50) begin guard++; @(negedge aclk); #1; end
    chk("reached RD_D", {31'd0, m_rready}, 32'd1);
    #2;
    chk_en = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("mid-rst arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("mid-rst rready", {31'd0, m_rready}, 32'd0);
    chk("mid-rst stall", {31'd0, mem_stall}, 32'd0);
    chk("mid-rst r_data", mem_r_data, 32'd0);
    mem_r = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; rst_epoch++; instr_id++; chk_en = 1'b1;
    do_instr(1, 0, 32'h0000_7004, 32'h0, 4'h0, 2'b00, 32'h0BAD_F00D, 0, 0, 0, 0, st_cnt);
    chk("post-rst stalls", st_cnt, 32'd3);
    chk("post-rst data", mem_r_data, 32'h0BAD_F00D);

    // random instruction stream with random slave timing
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [1:0] rs;
      k = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: rs = 2'b10;
        1: rs = 2'b11;
        default: rs = 2'b00;
      endcase
      do_instr(k[0], k[1], $urandom, $urandom, 4'($urandom), rs, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), st_cnt);
    end
    do_instr(0, 0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 0, 0, st_cnt);
    repeat (3) @(negedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
